// File: rtl/ce_frac_gen.sv
// Multi-channel fractional clock-enable generator: ce[i] pulses at num[i]/den[i] of refclk once PLL lock has settled.
// Latency: ce is registered; from a zeroed accumulator the first pulse lands on RUN cycle ceil(den/num).
// No backpressure: enables are free-running pulses; pause freezes phase, resync/cfg writes restart it.
module ce_frac_gen #(
  parameter int                    NUM_CH    = 3,
  parameter int                    ACC_W     = 16,
  parameter int                    LOCK_HOLD = 1024,
  parameter logic [NUM_CH*ACC_W-1:0] INIT_NUM = {16'd1, 16'd5, 16'd1},
  parameter logic [NUM_CH*ACC_W-1:0] INIT_DEN = {16'd12, 16'd402, 16'd2},
  localparam int                   CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              pll_locked,
  input  logic              pause,
  input  logic              resync,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_num,
  input  logic [ACC_W-1:0]  cfg_den,
  output logic [NUM_CH-1:0] ce,
  output logic              ready
);

  localparam int CNT_W = $clog2(LOCK_HOLD + 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              lock_m, lock_s;

  logic [ACC_W-1:0]  num_r [NUM_CH];
  logic [ACC_W-1:0]  den_r [NUM_CH];
  logic [ACC_W-1:0]  acc_r [NUM_CH];
  logic [ACC_W:0]    sum   [NUM_CH];
  logic [NUM_CH-1:0] cfg_hit;
  logic              leave_run;

  // Two-flop synchroniser for the asynchronous PLL lock.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= pll_locked;
      lock_s <= lock_m;
    end
  end

  // Lock state register, settle counter and registered ready flag.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      ready   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready   <= (state_d == RUN);
    end
  end

  // Next-state logic: the WAIT_LOCK edge that sees lock_s high counts as the first held cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      WAIT_LOCK: begin
        cnt_d = '0;
        if (lock_s) begin
          state_d = (LOCK_HOLD <= 1) ? RUN : SETTLE;
        end
      end
      SETTLE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!lock_s) begin
          state_d = WAIT_LOCK;
        end else if (cnt_d >= CNT_W'(LOCK_HOLD - 1)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
        end
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  // Per-channel decode of the config write and the widened accumulator sum.
  always_comb begin
    cfg_hit   = '0;
    leave_run = (state_d == WAIT_LOCK);
    for (int i = 0; i < NUM_CH; i++) begin
      cfg_hit[i] = cfg_we && (cfg_ch == CH_W'(i));
      sum[i]     = {1'b0, acc_r[i]} + {1'b0, num_r[i]};
    end
  end

  // Accumulators and enables, priority: lock loss > resync > cfg write > pause > accumulate.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      ce <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        acc_r[i] <= '0;
        num_r[i] <= INIT_NUM[i*ACC_W +: ACC_W];
        den_r[i] <= INIT_DEN[i*ACC_W +: ACC_W];
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (cfg_hit[i]) begin
          num_r[i] <= cfg_num;
          den_r[i] <= cfg_den;
        end
        if (leave_run || resync || cfg_hit[i]) begin
          acc_r[i] <= '0;
          ce[i]    <= 1'b0;
        end else if (state_q != RUN || pause) begin
          ce[i]    <= 1'b0;
        end else if (num_r[i] == '0 || den_r[i] == '0) begin
          // Disabled channel: keep the phase parked at zero.
          acc_r[i] <= '0;
          ce[i]    <= 1'b0;
        end else if (num_r[i] >= den_r[i]) begin
          // Ratio of one or more saturates to a continuous enable.
          acc_r[i] <= '0;
          ce[i]    <= 1'b1;
        end else if (sum[i] >= {1'b0, den_r[i]}) begin
          acc_r[i] <= ACC_W'(sum[i] - {1'b0, den_r[i]});
          ce[i]    <= 1'b1;
        end else begin
          acc_r[i] <= sum[i][ACC_W-1:0];
          ce[i]    <= 1'b0;
        end
      end
    end
  end

endmodule
